my_fifo_4_deep: RTL and testbench

//   4-entry, 16-bit-wide show-ahead FIFO using a valid/ready handshake on both sides.

---
 rtl/my_fifo_pkg.sv | 19 +
 rtl/my_mux_4_way.sv | 25 ++
 rtl/my_fifo_4_deep.sv | 95 +++++++++
 tb/tb_my_fifo_4_deep.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/my_fifo_pkg.sv
// Shared types and sizing for the 4-deep show-ahead FIFO.
// Pointer and count widths are fixed by the four-entry depth.
package my_fifo_pkg;

  localparam int DEPTH   = 4;
  localparam int PTR_W   = 2;
  localparam int COUNT_W = 3;

  typedef logic [15:0]      word_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [COUNT_W-1:0] cnt_t;

  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/my_mux_4_way.sv
// 4-way 16-bit word selector; purely combinational.
// Used as the FIFO read path with the read pointer as select.
module my_mux_4_way
  import my_fifo_pkg::*;
(
  output word_t out_data,
  input  word_t in0,
  input  word_t in1,
  input  word_t in2,
  input  word_t in3,
  input  ptr_t  sel
);

  always_comb begin
    out_data = '0;
    unique case (sel)
      2'd0: out_data = in0;
      2'd1: out_data = in1;
      2'd2: out_data = in2;
      2'd3: out_data = in3;
      default: out_data = '0;
    endcase
  end

endmodule

// File: rtl/my_fifo_4_deep.sv
// 4-entry, 16-bit show-ahead FIFO with valid/ready on both sides.
// Full/empty come from the occupancy count, not pointer compare.
module my_fifo_4_deep
  import my_fifo_pkg::*;
#(
  parameter int WIDTH             = 16,
  parameter int ALMOST_FULL_LEVEL = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COUNT_W-1:0] count,
  output logic               almost_full
);

  word_t mem_q [DEPTH];
  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  cnt_t  cnt_q, cnt_d;

  logic  push;
  logic  pop;
  logic [DEPTH-1:0] wr_en;
  word_t head;

  assign in_ready  = (cnt_q != CNT_FULL) & ~reset;
  assign out_valid = (cnt_q != '0) & ~reset;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // One-hot write enable, only live on an accepted push.
  always_comb begin
    wr_en = '0;
    if (push) begin
      unique case (wr_ptr_q)
        2'd0: wr_en = 4'b0001;
        2'd1: wr_en = 4'b0010;
        2'd2: wr_en = 4'b0100;
        2'd3: wr_en = 4'b1000;
        default: wr_en = '0;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) mem_q[i] <= word_t'(in_data);
      end
    end
  end

  my_mux_4_way u_rd_mux (
    .out_data (head),
    .in0      (mem_q[0]),
    .in1      (mem_q[1]),
    .in2      (mem_q[2]),
    .in3      (mem_q[3]),
    .sel      (rd_ptr_q)
  );

  // Outputs read as zero while reset is held, even before the clearing edge.
  assign out_data    = reset ? '0 : WIDTH'(head);
  assign count       = reset ? '0 : cnt_q;
  assign almost_full = ~reset &
                       (cnt_q >= cnt_t'(ALMOST_FULL_LEVEL));

endmodule

// File: tb/tb_my_fifo_4_deep.sv
// Randomized + directed scoreboard bench for my_fifo_4_deep.
// Model: a word queue with the occupancy rules of a 4-deep FIFO.
module tb_my_fifo_4_deep;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  count;
  logic        almost_full;

  localparam int AF = 3;

  my_fifo_4_deep #(.WIDTH(16), .ALMOST_FULL_LEVEL(AF)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_q [$];
  int mcnt = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit done = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: accepted pushes enter the expectation queue at the edge.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        exp_q.delete();
        mcnt = 0;
      end else begin
        bit ps, pp;
        ps = in_valid && (mcnt < 4);
        pp = out_ready && (mcnt > 0);
        if (ps) exp_q.push_back(in_data);
        mcnt = mcnt + (ps ? 1 : 0) - (pp ? 1 : 0);
      end
    end
  end

  // Monitor: mid-low-phase check of flags and the head word.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_out_data", out_data, 0);
      end else begin
        chk("count", count, mcnt);
        chk("in_ready", in_ready, (mcnt < 4) ? 1 : 0);
        chk("out_valid", out_valid, (mcnt > 0) ? 1 : 0);
        chk("almost_full", almost_full, (mcnt >= AF) ? 1 : 0);
        if (mcnt > 0) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
          end else begin
            chk("out_data", out_data, exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic step(input bit rst, input bit iv,
                      input logic [15:0] d, input bit ordy);
    @(negedge clk);
    reset     = rst;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  initial begin
    // reset then idle
    step(1, 0, 16'h0, 0);
    step(1, 0, 16'h0, 0);
    step(0, 0, 16'h0, 0);
    // fill, then overflow attempt
    step(0, 1, 16'h8000, 0);
    step(0, 1, 16'h0800, 0);
    step(0, 1, 16'h0080, 0);
    step(0, 1, 16'h0008, 0);
    step(0, 1, 16'hFFFF, 0);
    step(0, 1, 16'hFFFF, 1);
    // drain in order
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 1);
    // pointer wrap, one word in flight
    step(0, 1, 16'h0001, 0);
    for (int k = 2; k <= 6; k++) step(0, 1, 16'(k), 1);
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 0);
    // simultaneous push and pop at count=2
    step(0, 1, 16'h00AA, 0);
    step(0, 1, 16'h00BB, 0);
    step(0, 1, 16'h00CC, 1);
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 0);
    // reset mid-operation at count=3
    step(0, 1, 16'h1111, 0);
    step(0, 1, 16'h2222, 0);
    step(0, 1, 16'h3333, 0);
    step(1, 1, 16'h4444, 1);
    step(0, 1, 16'h1234, 0);
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 0);
    // random traffic with rare resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) != 0),
           16'($urandom),
           ($urandom_range(0, 2) != 0));
    end
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 0);
    @(negedge clk);
    #4;
    done = 1'b1;
  end

  initial begin
    wait (done);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
